// File: rtl/miniled_trace_capture.sv
// Single-clock trace buffer for the MiniLED driver: qualified probe sampling,
// pre-trigger ring buffer, four trigger modes and an oldest-first read port.
module miniled_trace_capture #(
    parameter int PROBE_W = 58,
    parameter int DEPTH   = 1024,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic               sample_en_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic [1:0]         trig_mode_i,
    input  logic               trig_ext_i,
    input  logic [PROBE_W-1:0] trig_value_i,
    input  logic [PROBE_W-1:0] trig_mask_i,
    input  logic [AW-1:0]      pre_count_i,
    input  logic               rd_en_i,
    input  logic [AW-1:0]      rd_idx_i,
    output logic [PROBE_W-1:0] rd_data_o,
    output logic               rd_valid_o,
    output logic [2:0]         state_o,
    output logic               done_o,
    output logic [AW-1:0]      trig_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      pre_q, pre_d;
    logic [AW-1:0]      pre_cnt_q, pre_cnt_d;
    logic [AW-1:0]      post_q, post_d;
    logic [AW-1:0]      start_q, start_d;
    logic               prev_match_q, prev_match_d;
    logic               done_q, done_d;
    logic [PROBE_W-1:0] rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic               wr_en;
    logic               match;
    logic               hit;
    logic [AW-1:0]      rd_addr;
    logic [PROBE_W-1:0] mem [DEPTH];

    assign match   = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
    assign rd_addr = start_q + rd_idx_i;

    always_comb begin
        case (trig_mode_i)
            2'd0:    hit = match;
            2'd1:    hit = match & ~prev_match_q;
            2'd2:    hit = 1'b1;
            default: hit = trig_ext_i;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        wptr_d       = wptr_q;
        pre_d        = pre_q;
        pre_cnt_d    = pre_cnt_q;
        post_d       = post_q;
        start_d      = start_q;
        prev_match_d = prev_match_q;
        done_d       = done_q;
        wr_en        = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (arm_i) begin
                    // pre_count_i is AW bits wide, so it never exceeds DEPTH-1
                    pre_d        = pre_count_i;
                    pre_cnt_d    = '0;
                    wptr_d       = '0;
                    done_d       = 1'b0;
                    prev_match_d = 1'b1;
                    state_d      = (pre_count_i == '0) ? S_ARMED : S_PRE;
                end
            end
            S_PRE: begin
                if (sample_en_i) begin
                    wr_en        = 1'b1;
                    wptr_d       = wptr_q + AW'(1);
                    pre_cnt_d    = pre_cnt_q + AW'(1);
                    prev_match_d = match;
                    if (pre_cnt_d == pre_q) state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (sample_en_i) begin
                    wr_en        = 1'b1;
                    wptr_d       = wptr_q + AW'(1);
                    prev_match_d = match;
                    if (hit) begin
                        start_d = wptr_q - pre_q;
                        post_d  = LAST - pre_q;
                        if (post_d == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_POST;
                        end
                    end
                end
            end
            S_POST: begin
                if (sample_en_i) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    post_d = post_q - AW'(1);
                    if (post_d == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including an arm in the same cycle
        if (abort_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            wptr_d  = '0;
            pre_d   = '0;
            wr_en   = 1'b0;
        end

        rd_valid_d = rd_en_i;
        rd_data_d  = rd_en_i ? mem[rd_addr] : rd_data_q;
    end

    // NOTE: the sample RAM has no reset so it maps onto block RAM; contents survive abort.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem[wptr_q] <= probe_i;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            wptr_q       <= '0;
            pre_q        <= '0;
            pre_cnt_q    <= '0;
            post_q       <= '0;
            start_q      <= '0;
            prev_match_q <= 1'b0;
            done_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            pre_q        <= pre_d;
            pre_cnt_q    <= pre_cnt_d;
            post_q       <= post_d;
            start_q      <= start_d;
            prev_match_q <= prev_match_d;
            done_q       <= done_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign state_o    = state_q;
    assign done_o     = done_q;
    assign trig_idx_o = pre_q;
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_miniled_trace_capture.sv
// Self-checking bench for miniled_trace_capture (PROBE_W = 8, DEPTH = 16):
// read expectations flow through a scoreboard queue, read vectors come from a table.
module tb_miniled_trace_capture;

    localparam int PW = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [PW-1:0] probe_i;
    logic          sample_en_i;
    logic          arm_i;
    logic          abort_i;
    logic [1:0]    trig_mode_i;
    logic          trig_ext_i;
    logic [PW-1:0] trig_value_i;
    logic [PW-1:0] trig_mask_i;
    logic [AW-1:0] pre_count_i;
    logic          rd_en_i;
    logic [AW-1:0] rd_idx_i;
    logic [PW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic [2:0]    state_o;
    logic          done_o;
    logic [AW-1:0] trig_idx_o;

    miniled_trace_capture #(.PROBE_W(PW), .DEPTH(D)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .probe_i      (probe_i),
        .sample_en_i  (sample_en_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .trig_mode_i  (trig_mode_i),
        .trig_ext_i   (trig_ext_i),
        .trig_value_i (trig_value_i),
        .trig_mask_i  (trig_mask_i),
        .pre_count_i  (pre_count_i),
        .rd_en_i      (rd_en_i),
        .rd_idx_i     (rd_idx_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .state_o      (state_o),
        .done_o       (done_o),
        .trig_idx_o   (trig_idx_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [AW-1:0] idx;
        logic [PW-1:0] exp;
    } rd_vec_t;

    rd_vec_t       vec [D];
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] rec [$];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic feed(input logic [PW-1:0] val);
        probe_i     = val;
        sample_en_i = 1'b1;
        step();
    endtask

    task automatic arm(input logic [1:0] mode, input logic [PW-1:0] val,
                       input logic [PW-1:0] mask, input logic [AW-1:0] pre);
        trig_mode_i  = mode;
        trig_value_i = val;
        trig_mask_i  = mask;
        pre_count_i  = pre;
        sample_en_i  = 1'b0;
        arm_i        = 1'b1;
        step();
        arm_i        = 1'b0;
    endtask

    // Back-to-back reads of the first n table entries, then drain the scoreboard
    task automatic read_table(input int n);
        sample_en_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            rd_en_i  = 1'b1;
            rd_idx_i = vec[i].idx;
            exp_q.push_back(vec[i].exp);
            step();
        end
        rd_en_i = 1'b0;
        step();
        step();
        check("rd_drain", exp_q.size(), 0);
    endtask

    always @(negedge sys_clk) begin
        if (sys_rst_n && rd_valid_o) begin
            if (exp_q.size() == 0) check("rd_spurious_valid", rd_valid_o, 0);
            else check("rd_data", rd_data_o, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] p;

        probe_i = '0; sample_en_i = 0; arm_i = 0; abort_i = 0; trig_mode_i = 0;
        trig_ext_i = 0; trig_value_i = 0; trig_mask_i = 0; pre_count_i = 0;
        rd_en_i = 0; rd_idx_i = 0;

        for (int i = 0; i < D; i++) vec[i] = '{idx: AW'(i), exp: PW'(8'h26 + i)};

        repeat (3) step();
        sys_rst_n = 1'b1;
        step();
        check("reset_state", state_o, 0);
        check("reset_done", done_o, 0);
        check("reset_trig_idx", trig_idx_o, 0);
        check("reset_rd_valid", rd_valid_o, 0);
        check("reset_rd_data", rd_data_o, 0);

        // Level trigger on a ramp
        p = 8'h00;
        probe_i = p;
        arm(2'd0, 8'h2A, 8'hFF, 4'd4);
        check("level_state_pre", state_o, 1);
        for (int c = 0; c < 100 && !done_o; c++) begin
            p = p + 8'd1;
            feed(p);
        end
        check("level_last_sample", p, 8'h35);
        check("level_done", done_o, 1);
        check("level_state_done", state_o, 4);
        check("level_trig_idx", trig_idx_o, 4);
        read_table(D);

        // Edge trigger, rearmed from DONE with the probe already matching
        probe_i = 8'h2A;
        arm(2'd1, 8'h2A, 8'hFF, 4'd2);
        check("rearm_done_drop", done_o, 0);
        check("edge_state_pre", state_o, 1);
        feed(8'h2A); feed(8'h2A);
        check("edge_state_armed", state_o, 2);
        feed(8'h2A); feed(8'h2A); feed(8'h00);
        check("edge_no_trigger_while_high", state_o, 2);
        feed(8'h2A);
        check("edge_state_post", state_o, 3);
        for (int i = 0; i < 13; i++) feed(PW'(8'h50 + i));
        check("edge_done", done_o, 1);
        check("edge_trig_idx", trig_idx_o, 2);
        vec[0].exp = 8'h2A; vec[1].exp = 8'h00; vec[2].exp = 8'h2A;
        for (int i = 3; i < D; i++) vec[i].exp = PW'(8'h50 + i - 3);
        read_table(D);

        // Force trigger with no pre-trigger samples; overwrites the previous capture
        arm(2'd2, 8'h00, 8'h00, 4'd0);
        check("force_state_armed", state_o, 2);
        for (int i = 0; i < D; i++) begin
            feed(PW'(8'h80 + i));
            if (i == D - 2) check("force_done_not_early", done_o, 0);
            if (i == D - 1) check("force_done_after_16", done_o, 1);
        end
        check("force_trig_idx", trig_idx_o, 0);
        for (int i = 0; i < D; i++) vec[i].exp = PW'(8'h80 + i);
        read_table(D);

        // Maximum pre count with the qualifier high only every third cycle
        arm(2'd0, 8'h00, 8'h00, 4'd15);
        rec.delete();
        for (int c = 0; c < 200 && !done_o; c++) begin
            sample_en_i = (c % 3 == 2);
            probe_i     = PW'(c * 7 + 3);
            if (sample_en_i) rec.push_back(probe_i);
            step();
        end
        sample_en_i = 1'b0;
        check("clamp_sample_count", rec.size(), D);
        check("clamp_done", done_o, 1);
        check("clamp_trig_idx", trig_idx_o, 15);
        for (int i = 0; i < D && i < rec.size(); i++) vec[i].exp = rec[i];
        read_table(D);

        // Abort during POST
        arm(2'd2, 8'h00, 8'h00, 4'd0);
        feed(8'h11); feed(8'h12); feed(8'h13);
        check("abort_in_post", state_o, 3);
        sample_en_i = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("abort_state_idle", state_o, 0);
        check("abort_done_low", done_o, 0);
        step();
        check("abort_done_stays_low", done_o, 0);

        // Arm and abort together
        arm_i = 1'b1; abort_i = 1'b1;
        step();
        arm_i = 1'b0; abort_i = 1'b0;
        check("arm_abort_idle", state_o, 0);
        step();
        check("arm_abort_still_idle", state_o, 0);

        // Asynchronous reset while ARMED
        arm(2'd0, 8'hEE, 8'hFF, 4'd3);
        for (int i = 0; i < 5; i++) feed(8'h01);
        check("rst_pre_armed", state_o, 2);
        check("rst_pre_trig_idx", trig_idx_o, 3);
        sample_en_i = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rst_state", state_o, 0);
        check("rst_done", done_o, 0);
        check("rst_trig_idx", trig_idx_o, 0);
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        step();
        sys_rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
